// File: rtl/grf_sb_if.sv
// Bundled port set of the D-stage register file: read ports, two write ports,
// scoreboard set port, status outputs and the trace debug outputs.
interface grf_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  // Status and trace outputs are plain combinational outputs. The trace
  // fields are meaningful only in a cycle whose trN_v is 1.
  logic              req;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic [31:0]       pc0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic [31:0]       pc1;
  logic              set_en;
  logic [AW-1:0]     set_addr;
  logic              busy_any;
  logic [(1<<AW)-1:0] pending;
  logic              tr0_v;
  logic [31:0]       tr0_pc;
  logic [AW-1:0]     tr0_wa;
  logic [DW-1:0]     tr0_wd;
  logic              tr1_v;
  logic [31:0]       tr1_pc;
  logic [AW-1:0]     tr1_wa;
  logic [DW-1:0]     tr1_wd;

  modport master (
    output req, ra, we0, wa0, wd0, pc0, we1, wa1, wd1, pc1, set_en, set_addr,
    input  rd, rd_busy, busy_any, pending,
    input  tr0_v, tr0_pc, tr0_wa, tr0_wd, tr1_v, tr1_pc, tr1_wa, tr1_wd
  );

  modport slave (
    input  req, ra, we0, wa0, wd0, pc0, we1, wa1, wd1, pc1, set_en, set_addr,
    output rd, rd_busy, busy_any, pending,
    output tr0_v, tr0_pc, tr0_wa, tr0_wd, tr1_v, tr1_pc, tr1_wa, tr1_wd
  );
endinterface

// File: rtl/grf_sb.sv
// General register file with two write ports, optional write-through bypass
// and a pending-write scoreboard for late (multiply/divide) results.
module grf_sb #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic   clk,
  input  logic   reset,
  grf_sb_if.slave bus
);
  localparam int   NREG = 1 << AW;
  localparam logic BYP  = (BYPASS != 0);

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic ew0;
  logic ew1;
  logic es;

  assign ew0 = bus.we0    & ~bus.req & (bus.wa0      != '0);
  assign ew1 = bus.we1    & ~bus.req & (bus.wa1      != '0);
  assign es  = bus.set_en & ~bus.req & (bus.set_addr != '0);

  // Issue of a new late op to a register wins over a result landing on it.
  always_comb begin
    pend_d = pend_q;
    if (ew1) pend_d[bus.wa1]      = 1'b0;
    if (es)  pend_d[bus.set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Port 0 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (ew1) regs_q[bus.wa1] <= bus.wd1;
      if (ew0) regs_q[bus.wa0] <= bus.wd0;
      pend_q <= pend_d;
    end
  end

  logic [NR*DW-1:0] rd_w;
  logic [NR-1:0]    busy_w;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          zero;
    logic          hit0;
    logic          hit1;
    assign a    = bus.ra[k*AW +: AW];
    assign zero = (a == '0);
    assign hit0 = BYP & ew0 & (bus.wa0 == a);
    assign hit1 = BYP & ew1 & (bus.wa1 == a);
    assign rd_w[k*DW +: DW] = zero ? '0 :
                              hit0 ? bus.wd0 :
                              hit1 ? bus.wd1 : regs_q[a];
    // A result landing this cycle releases the stall immediately.
    assign busy_w[k] = pend_q[a] & ~zero & ~hit1;
  end

  assign bus.rd       = rd_w;
  assign bus.rd_busy  = busy_w;
  assign bus.busy_any = |pend_q;
  assign bus.pending  = pend_q;

  // Trace fields: register-0 writes still trace, reset cycles do not.
  assign bus.tr0_v  = bus.we0 & ~bus.req & ~reset;
  assign bus.tr0_pc = bus.pc0;
  assign bus.tr0_wa = bus.wa0;
  assign bus.tr0_wd = bus.wd0;
  assign bus.tr1_v  = bus.we1 & ~bus.req & ~reset;
  assign bus.tr1_pc = bus.pc1;
  assign bus.tr1_wa = bus.wa1;
  assign bus.tr1_wd = bus.wd1;
endmodule

// File: tb/tb_grf_sb.sv
// Directed plus randomized bench for grf_sb, checked against an array-based
// model of the register file and scoreboard.
module tb_grf_sb;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NR     = 2;
  localparam int BYPASS = 1;
  localparam int NREG   = 1 << AW;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [DW-1:0] mdl_reg  [NREG];
  logic          mdl_pend [NREG];
  logic [63:0]   exp_q[$];

  grf_sb_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

  grf_sb #(.DW(DW), .AW(AW), .NR(NR), .BYPASS(BYPASS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic m_ew0();
    return bus.we0 && !bus.req && bus.wa0 != 0;
  endfunction
  function automatic logic m_ew1();
    return bus.we1 && !bus.req && bus.wa1 != 0;
  endfunction

  // Value a reader of register a sees this cycle, from the architectural rules.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS != 0 && m_ew0() && bus.wa0 == a) return bus.wd0;
    if (BYPASS != 0 && m_ew1() && bus.wa1 == a) return bus.wd1;
    return mdl_reg[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (a == 0 || !mdl_pend[a]) return 1'b0;
    if (BYPASS != 0 && m_ew1() && bus.wa1 == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_any();
    for (int i = 0; i < NREG; i++) if (mdl_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    logic          any;
    for (int k = 0; k < NR; k++) begin
      a = bus.ra[k*AW +: AW];
      exp_q.push_back({32'h0, m_read(a)});
      chk($sformatf("rd%0d[a=%0d]", k, a), {32'h0, bus.rd[k*DW +: DW]}, exp_q.pop_front());
      chk($sformatf("rd_busy%0d[a=%0d]", k, a), {63'h0, bus.rd_busy[k]}, {63'h0, m_busy(a)});
    end
    any = m_any();
    chk("busy_any", {63'h0, bus.busy_any}, {63'h0, any});
    chk("tr0_v", {63'h0, bus.tr0_v}, {63'h0, bus.we0 & ~bus.req});
    chk("tr1_v", {63'h0, bus.tr1_v}, {63'h0, bus.we1 & ~bus.req});
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mdl_reg[i]  = '0;
        mdl_pend[i] = 1'b0;
      end
    end else if (!bus.req) begin
      if (bus.we1 && bus.wa1 != 0) begin
        mdl_reg[bus.wa1]  = bus.wd1;
        mdl_pend[bus.wa1] = 1'b0;
      end
      if (bus.we0 && bus.wa0 != 0) mdl_reg[bus.wa0] = bus.wd0;
      if (bus.set_en && bus.set_addr != 0) mdl_pend[bus.set_addr] = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    bus.req = 0; bus.ra = '0;
    bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0; bus.pc0 = '0;
    bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0; bus.pc1 = '0;
    bus.set_en = 0; bus.set_addr = '0;
  endtask

  task automatic set_ra(input int a0, input int a1);
    bus.ra = {AW'(a1), AW'(a0)};
  endtask

  // One clock: check at the falling edge, print trace, then advance model.
  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      check_outputs();
      if (bus.tr0_v) $display("@%h: $%d <= %h", bus.tr0_pc, bus.tr0_wa, bus.tr0_wd);
      if (bus.tr1_v) $display("@%h: $%d <= %h", bus.tr1_pc, bus.tr1_wa, bus.tr1_wd);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < NREG; i++) begin
      mdl_reg[i]  = 'x;
      mdl_pend[i] = 1'bx;
    end
    idle();
    rst = 1;
    #1;
    cycle();
    rst = 0;

    // Reset state: every address on both ports.
    for (int i = 0; i < NREG; i += 2) begin
      set_ra(i, i + 1);
      cycle();
    end

    // Port-0 write with same-cycle read, then the following cycle.
    bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'h12345678; bus.pc0 = 32'h0000_1000;
    set_ra(5, 0);
    cycle();
    idle(); set_ra(5, 5);
    cycle();

    // Both ports to register 8: port 0 wins.
    bus.we0 = 1; bus.wa0 = 8; bus.wd0 = 32'hAAAA; bus.pc0 = 32'h0000_1004;
    bus.we1 = 1; bus.wa1 = 8; bus.wd1 = 32'hBBBB; bus.pc1 = 32'h0000_0ff0;
    set_ra(8, 8);
    cycle();
    idle(); set_ra(8, 5);
    cycle();
    chk("reg8_after_collision", {32'h0, bus.rd[DW-1:0]}, 64'hAAAA);

    // Scoreboard set on 9, hold three cycles, then the late result lands.
    bus.set_en = 1; bus.set_addr = 9; set_ra(0, 9);
    cycle();
    idle(); set_ra(0, 9);
    for (int i = 0; i < 3; i++) cycle();
    bus.we1 = 1; bus.wa1 = 9; bus.wd1 = 32'h77; bus.pc1 = 32'h0000_2000;
    set_ra(0, 9);
    cycle();
    idle(); set_ra(9, 9);
    cycle();

    // Interrupt request suppresses everything.
    bus.req = 1;
    bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'hDEAD0003;
    bus.we1 = 1; bus.wa1 = 4; bus.wd1 = 32'hDEAD0004;
    bus.set_en = 1; bus.set_addr = 6; set_ra(3, 4);
    cycle();
    idle(); set_ra(3, 4);
    cycle();
    set_ra(6, 6);
    cycle();

    // Register 0 on every write path.
    bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 32'h0BAD0000; bus.pc0 = 32'h0000_3000;
    bus.we1 = 1; bus.wa1 = 0; bus.wd1 = 32'h0BAD0001; bus.pc1 = 32'h0000_3004;
    bus.set_en = 1; bus.set_addr = 0; set_ra(0, 0);
    cycle();
    idle(); set_ra(0, 0);
    cycle();

    // Reset while bits are pending, then a late result writes normally.
    bus.set_en = 1; bus.set_addr = 12;
    cycle();
    bus.set_addr = 13;
    cycle();
    idle();
    rst = 1;
    cycle();
    rst = 0; set_ra(12, 13);
    cycle();
    bus.we1 = 1; bus.wa1 = 12; bus.wd1 = 32'hC0FFEE; set_ra(12, 13);
    cycle();
    idle(); set_ra(12, 13);
    cycle();

    // Randomized traffic, addresses biased toward a small window for collisions.
    for (int n = 0; n < 600; n++) begin
      bus.req      = ($urandom_range(0, 9) == 0);
      bus.we0      = $urandom_range(0, 1);
      bus.wa0      = AW'($urandom_range(0, 7));
      bus.wd0      = $urandom;
      bus.pc0      = $urandom;
      bus.we1      = $urandom_range(0, 1);
      bus.wa1      = AW'($urandom_range(0, 7));
      bus.wd1      = $urandom;
      bus.pc1      = $urandom;
      bus.set_en   = ($urandom_range(0, 2) == 0);
      bus.set_addr = AW'($urandom_range(0, 7));
      set_ra($urandom_range(0, 8), $urandom_range(0, NREG - 1));
      rst = ($urandom_range(0, 63) == 0);
      cycle();
      rst = 0;
    end

    idle();
    for (int i = 0; i < NREG; i += 2) begin
      set_ra(i, i + 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/grf_sb.md
# grf_sb

Parametrised general register file for the pipelined CPU: a configurable number of read ports, two write ports, optional write-through bypass, and a pending-write scoreboard for multi-cycle units. Port 0 carries the in-order W-stage writeback. Port 1 carries late results from the multiply/divide unit. The scoreboard tells the hazard unit which source registers still await a late result. It sits in the D stage and replaces the single-write-port register file.

## Interface
- DW, 32, data width in bits
- AW, 5, register address width; register count = 2^AW
- NR, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writes are visible on read ports and busy outputs; 0 = reads return stored value only
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req  in  1  interrupt/exception request; when 1, all writes and scoreboard sets this cycle are suppressed
- ra  in  NR*AW  read addresses, port k at bits [k*AW +: AW]
- rd  out  NR*DW  read data, port k at bits [k*DW +: DW]
- rd_busy  out  NR  port k source register has a pending late write
- we0, wa0 (AW), wd0 (DW), pc0 (32)  in  writeback port 0 and its instruction PC
- we1, wa1 (AW), wd1 (DW), pc1 (32)  in  late-result port 1 and its instruction PC
- set_en, set_addr (AW)  in  mark register set_addr pending (late-unit issue)
- busy_any  out  1  OR of all pending bits

## Operation
- Storage:
  - reg array [0 .. 2^AW-1] of DW bits
  - pending bit vector of 2^AW bits
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are dropped.
  - set_en to it is dropped.
- Effective write enables:
  - ew0 = we0 & ~req & (wa0 != 0)
  - ew1 = we1 & ~req & (wa1 != 0)
  - es = set_en & ~req & (set_addr != 0)
- Writes on rising edge: reg[wa0] <= wd0 if ew0; reg[wa1] <= wd1 if ew1.
- Both ports hitting the same address: port 0 wins. Port 0 is younger in program order.
- Pending bits:
  - ew1 clears pending[wa1].
  - es sets pending[set_addr].
  - Set and clear of the same address in one cycle: set wins.
  - Port 0 writes never touch pending.
- Read, BYPASS=1, for port k with address a:
  - a == 0: result 0.
  - ew0 & wa0 == a: result wd0.
  - Otherwise ew1 & wa1 == a: result wd1.
  - Otherwise: result reg[a].
- Read, BYPASS=0: rd = reg[a], or 0 for a == 0.
- rd_busy[k]:
  - Base value: pending[a] & (a != 0).
  - With BYPASS=1 it is additionally masked by ~(ew1 & wa1 == a), so a result arriving this cycle releases the stall in the same cycle.
- busy_any = |pending (registered state, no bypass).
- Trace output, simulation only:
  - Each cycle with we0 & ~req: print "@%h: $%d <= %h" with pc0, wa0, wd0. This includes wa0 == 0.
  - Then, if we1 & ~req: print the same line with pc1, wa1, wd1.
  - Port 0 line always prints first.

## Timing
- Reset:
  - One clock with reset=1 zeroes all registers and all pending bits.
  - Afterwards every rd = 0, rd_busy = 0, busy_any = 0.
  - reset overrides any write or set in the same cycle, and no trace line is printed in that cycle.
- Read path is combinational from ra, we*, wa*, wd*, req and stored state: zero-cycle latency.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, via the forward path.
  - BYPASS=0: 1 cycle, visible the cycle after the edge.
- Scoreboard:
  - set visible on rd_busy one cycle after the set edge.
  - clear visible in the same cycle with BYPASS=1, otherwise the next cycle.
- req = 1 cycle: register and pending state are unchanged across the edge, and the bypass paths are disabled.
- reset asserted while bits are pending: all pending bits clear. A late result arriving after reset still writes its register normally.

## Test plan
- Reset then read all 32 addresses on both ports -> every rd = 0, rd_busy = 0, busy_any = 0.
- we0=1, wa0=5, wd0=0x12345678, ra0=5 in the same cycle -> BYPASS=1: rd0 = 0x12345678 that cycle. BYPASS=0: old value that cycle, new value the next. Trace prints "$ 5 <= 12345678" with pc0.
- we0 and we1 both target register 8 (wd0=0xAAAA, wd1=0xBBBB) -> reg[8] = 0xAAAA. Trace lines print in order port 0 then port 1.
- set_en to register 9, then ra1=9 for 3 cycles -> rd_busy[1] = 1 and busy_any = 1. Then we1 to register 9 with wd1=0x77 -> same cycle rd_busy[1] = 0 and rd1 = 0x77; next cycle busy_any = 0.
- req=1 with we0 to register 3, we1 to register 4 and set_en to register 6 -> registers 3, 4 and 6 unchanged, pending[6] = 0, no trace output.
- Writes to register 0 on both ports plus set_en to register 0 -> rd = 0 and rd_busy = 0. Port 0 still traces "$ 0 <= ...".
